// File: rtl/chip8_program_loader.sv
// chip8_program_loader
//   Boot-time copier: moves LOAD_LEN bytes of the program ROM, starting at
//   LOAD_BASE, into main RAM at the same addresses while holding the CPU in
//   reset. Once the copy finishes, the single RAM port becomes a transparent
//   pass-through for the CPU. A start pulse in DONE triggers a reload.
//
//   Optional build macro: CHIP8_LOADER_CHECKSUM_EN
//     When defined, adds output checksum[7:0], the mod-256 sum of every byte
//     written by the most recent load.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             single-cycle load request (ignored while busy)
//   rom_address/data  combinational ROM read port
//   cpu_mem_*         CPU side of the RAM port
//   mem_*             RAM port (loader while not DONE, CPU in DONE)
//   cpu_rst_n         low except in DONE
//   busy              high in LOAD and DRAIN
//   done              high in DONE
module chip8_program_loader #(
   parameter logic [11:0] LOAD_BASE = 12'h200,
   parameter logic [12:0] LOAD_LEN  = 13'd3584,
   parameter bit          AUTOSTART = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [11:0] rom_address,
   input  logic [7:0]  rom_data,
   input  logic [11:0] cpu_mem_address,
   input  logic        cpu_mem_we,
   input  logic [7:0]  cpu_mem_wdata,
   output logic [11:0] mem_address,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   output logic        cpu_rst_n,
   output logic        busy,
   output logic        done
`ifdef CHIP8_LOADER_CHECKSUM_EN
   ,
   output logic [7:0]  checksum
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state, state_nx;
   logic [12:0] cnt;
   logic        we_q;
   logic [11:0] addr_q;
   logic [7:0]  data_q;
   logic        last_byte;
   logic        load_entry;

   assign last_byte  = (cnt == LOAD_LEN - 13'd1);
   assign load_entry = (state_nx == LOAD) && (state != LOAD);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic. IDLE is only reachable from reset, so with AUTOSTART
   // set, being in IDLE means this is the first cycle after reset release.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (AUTOSTART || start) begin
               state_nx = (LOAD_LEN == 13'd0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (last_byte) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            state_nx = DONE;
         end
         DONE: begin
            // A zero-length reload has nothing to copy; stay in DONE.
            if (start && (LOAD_LEN != 13'd0)) begin
               state_nx = LOAD;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Outputs
   always_comb begin
      busy        = (state == LOAD) || (state == DRAIN);
      done        = (state == DONE);
      cpu_rst_n   = (state == DONE);
      rom_address = (state == LOAD) ? (LOAD_BASE + cnt[11:0]) : LOAD_BASE;
      if (state == DONE) begin
         mem_address = cpu_mem_address;
         mem_we      = cpu_mem_we;
         mem_wdata   = cpu_mem_wdata;
      end else begin
         mem_address = addr_q;
         mem_we      = we_q;
         mem_wdata   = data_q;
      end
   end

   // Loader write stage: one ROM byte captured per LOAD cycle, presented to
   // the RAM on the following cycle. DRAIN exists only to present the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else if (load_entry) begin
         cnt  <= '0;
         we_q <= 1'b0;
      end else if (state == LOAD) begin
         cnt    <= cnt + 13'd1;
         we_q   <= 1'b1;
         addr_q <= rom_address;
         data_q <= rom_data;
      end else begin
         we_q <= 1'b0;
      end
   end

`ifdef CHIP8_LOADER_CHECKSUM_EN
   // Sum of the bytes captured in LOAD; final once the state reaches DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= '0;
      end else if (load_entry) begin
         checksum <= '0;
      end else if (state == LOAD) begin
         checksum <= checksum + rom_data;
      end
   end
`endif

endmodule

// File: tb/tb_chip8_program_loader.sv
// tb_chip8_program_loader
//   Directed bench for chip8_program_loader. Three instances share clock and
//   reset:
//     u_a  default base 0x200, 18 bytes, autostart
//     u_b  base 0xFFE, 4 bytes, explicit start (address wrap)
//     u_c  zero-length load, explicit start
module tb_chip8_program_loader;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [7:0] rom [0:4095];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- instance A ----------------
   logic        start_a;
   logic [11:0] rom_addr_a, cpu_addr_a, mem_addr_a;
   logic [7:0]  rom_data_a, cpu_wdata_a, mem_wdata_a;
   logic        cpu_we_a, mem_we_a, cpu_rst_n_a, busy_a, done_a;
`ifdef CHIP8_LOADER_CHECKSUM_EN
   logic [7:0]  csum_a, csum_b, csum_c;
`endif
   assign rom_data_a = rom[rom_addr_a];

   chip8_program_loader #(.LOAD_BASE(12'h200), .LOAD_LEN(13'd18), .AUTOSTART(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a),
      .rom_address(rom_addr_a), .rom_data(rom_data_a),
      .cpu_mem_address(cpu_addr_a), .cpu_mem_we(cpu_we_a), .cpu_mem_wdata(cpu_wdata_a),
      .mem_address(mem_addr_a), .mem_we(mem_we_a), .mem_wdata(mem_wdata_a),
      .cpu_rst_n(cpu_rst_n_a), .busy(busy_a), .done(done_a)
`ifdef CHIP8_LOADER_CHECKSUM_EN
      , .checksum(csum_a)
`endif
   );

   logic [7:0] ram_a [0:4095];
   int we_cnt_a = 0;
   always @(posedge clk) begin
      if (mem_we_a) begin
         ram_a[mem_addr_a] <= mem_wdata_a;
         we_cnt_a <= we_cnt_a + 1;
      end
   end

   // ---------------- instance B ----------------
   logic        start_b;
   logic [11:0] rom_addr_b, cpu_addr_b, mem_addr_b;
   logic [7:0]  rom_data_b, cpu_wdata_b, mem_wdata_b;
   logic        cpu_we_b, mem_we_b, cpu_rst_n_b, busy_b, done_b;
   assign rom_data_b = rom[rom_addr_b];

   chip8_program_loader #(.LOAD_BASE(12'hFFE), .LOAD_LEN(13'd4), .AUTOSTART(1'b0)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b),
      .rom_address(rom_addr_b), .rom_data(rom_data_b),
      .cpu_mem_address(cpu_addr_b), .cpu_mem_we(cpu_we_b), .cpu_mem_wdata(cpu_wdata_b),
      .mem_address(mem_addr_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b),
      .cpu_rst_n(cpu_rst_n_b), .busy(busy_b), .done(done_b)
`ifdef CHIP8_LOADER_CHECKSUM_EN
      , .checksum(csum_b)
`endif
   );

   logic [11:0] log_addr_b [0:15];
   logic [7:0]  log_data_b [0:15];
   int we_cnt_b = 0;
   always @(posedge clk) begin
      if (mem_we_b) begin
         log_addr_b[we_cnt_b[3:0]] <= mem_addr_b;
         log_data_b[we_cnt_b[3:0]] <= mem_wdata_b;
         we_cnt_b <= we_cnt_b + 1;
      end
   end

   // ---------------- instance C ----------------
   logic        start_c;
   logic [11:0] rom_addr_c, mem_addr_c;
   logic [7:0]  rom_data_c, mem_wdata_c;
   logic        mem_we_c, cpu_rst_n_c, busy_c, done_c;
   assign rom_data_c = rom[rom_addr_c];

   chip8_program_loader #(.LOAD_BASE(12'h200), .LOAD_LEN(13'd0), .AUTOSTART(1'b0)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_c),
      .rom_address(rom_addr_c), .rom_data(rom_data_c),
      .cpu_mem_address(12'h000), .cpu_mem_we(1'b0), .cpu_mem_wdata(8'h00),
      .mem_address(mem_addr_c), .mem_we(mem_we_c), .mem_wdata(mem_wdata_c),
      .cpu_rst_n(cpu_rst_n_c), .busy(busy_c), .done(done_c)
`ifdef CHIP8_LOADER_CHECKSUM_EN
      , .checksum(csum_c)
`endif
   );

   int we_cnt_c = 0;
   always @(posedge clk) begin
      if (mem_we_c) we_cnt_c <= we_cnt_c + 1;
   end

   // Called at the negedge right after rst_n is released. Step i means i
   // posedges have passed; the first one takes the autostart.
   task automatic run_load_a(input string tag, input int start_at);
      int wc0;
      wc0 = we_cnt_a;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         start_a = (start_at != 0) && (i == start_at);
         if (i == 1) begin
            check({tag, "_busy_rise"}, busy_a, 1);
            check({tag, "_we_first_idle"}, mem_we_a, 0);
         end
         if (i == 2) begin
            check({tag, "_we_first"}, mem_we_a, 1);
            check({tag, "_addr_first"}, mem_addr_a, 12'h200);
            check({tag, "_data_first"}, mem_wdata_a, 8'h60);
            check({tag, "_cpu_held"}, cpu_rst_n_a, 0);
         end
         if (i == 19) begin
            check({tag, "_done_early"}, done_a, 0);
            check({tag, "_we_last"}, mem_we_a, 1);
            check({tag, "_addr_last"}, mem_addr_a, 12'h211);
            check({tag, "_data_last"}, mem_wdata_a, 8'h04);
         end
         if (i == 20) begin
            check({tag, "_done"}, done_a, 1);
            check({tag, "_cpu_rst_n"}, cpu_rst_n_a, 1);
            check({tag, "_busy_fall"}, busy_a, 0);
         end
      end
      start_a = 1'b0;
      check({tag, "_write_count"}, we_cnt_a - wc0, 18);
   endtask

   logic [7:0] prog [0:17];

   initial begin
      prog = '{8'h60, 8'hEA, 8'h61, 8'hAC, 8'h62, 8'hAA, 8'h63, 8'hE9, 8'hA0,
               8'h00, 8'hF3, 8'h55, 8'hA0, 8'h00, 8'h60, 8'h00, 8'hD0, 8'h04};
      for (int unsigned a = 0; a < 4096; a++) rom[a] = a[7:0] ^ 8'h5A;
      for (int unsigned k = 0; k < 18; k++) rom[12'h200 + k] = prog[k];

      rst_n = 1'b0;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      cpu_addr_a = '0; cpu_we_a = 1'b0; cpu_wdata_a = '0;
      cpu_addr_b = '0; cpu_we_b = 1'b0; cpu_wdata_b = '0;

      repeat (2) @(negedge clk);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_cpu_rst_n", cpu_rst_n_a, 0);
      check("rst_mem_we", mem_we_a, 0);
      check("rst_mem_addr", mem_addr_a, 12'h000);
      check("rst_rom_addr", rom_addr_a, 12'h200);
      check("rst_rom_addr_b", rom_addr_b, 12'hFFE);

      // Boot load
      rst_n = 1'b1;
      run_load_a("boot", 0);
      check("ram_200", ram_a[12'h200], 8'h60);
      check("ram_20B", ram_a[12'h20B], 8'h55);
      check("ram_211", ram_a[12'h211], 8'h04);
`ifdef CHIP8_LOADER_CHECKSUM_EN
      check("checksum", csum_a, 8'h6B);
`endif

      // CPU pass-through in DONE
      cpu_addr_a = 12'h300; cpu_we_a = 1'b1; cpu_wdata_a = 8'hA5;
      #1;
      check("pt_addr", mem_addr_a, 12'h300);
      check("pt_we", mem_we_a, 1);
      check("pt_wdata", mem_wdata_a, 8'hA5);
      @(negedge clk);
      cpu_we_a = 1'b0;
      check("pt_ram_300", ram_a[12'h300], 8'hA5);

      // start pulsed on cycle 5 of the load is ignored
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_load_a("start_mid", 5);

      // Reset mid-load aborts immediately, reload follows release
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (7) @(negedge clk);
      check("abort_busy_before", busy_a, 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", busy_a, 0);
      check("abort_mem_we", mem_we_a, 0);
      check("abort_cpu_rst_n", cpu_rst_n_a, 0);
      check("abort_rom_addr", rom_addr_a, 12'h200);
      @(negedge clk);
      rst_n = 1'b1;
      run_load_a("restart", 0);

      // Wrapped load on B, with a CPU write attempted throughout the load
      begin
         int wb0;
         wb0 = we_cnt_b;
         check("b_idle", busy_b, 0);
         start_b = 1'b1;
         cpu_addr_b = 12'h123; cpu_we_b = 1'b1; cpu_wdata_b = 8'h77;
         @(negedge clk);
         start_b = 1'b0;
         check("b_busy", busy_b, 1);
         check("b_rom_addr0", rom_addr_b, 12'hFFE);
         repeat (4) @(negedge clk);
         check("b_drain_addr", mem_addr_b, 12'h001);
         check("b_drain_done", done_b, 0);
         cpu_we_b = 1'b0;
         @(negedge clk);
         check("b_done", done_b, 1);
         check("b_count", we_cnt_b - wb0, 4);
         check("b_addr0", log_addr_b[0], 12'hFFE);
         check("b_data0", log_data_b[0], 8'hA4);
         check("b_addr1", log_addr_b[1], 12'hFFF);
         check("b_data1", log_data_b[1], 8'hA5);
         check("b_addr2", log_addr_b[2], 12'h000);
         check("b_data2", log_data_b[2], 8'h5A);
         check("b_addr3", log_addr_b[3], 12'h001);
         check("b_data3", log_data_b[3], 8'h5B);
      end

      // Zero-length load on C
      begin
         int wc0;
         wc0 = we_cnt_c;
         check("c_idle_done", done_c, 0);
         start_c = 1'b1;
         @(negedge clk);
         start_c = 1'b0;
         check("c_done", done_c, 1);
         check("c_cpu_rst_n", cpu_rst_n_c, 1);
         check("c_busy", busy_c, 0);
         @(negedge clk);
         check("c_no_writes", we_cnt_c - wc0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
